// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm
//  Purpose  : Multicycle ARM main-control FSM with memory-ready stalls,
//             retired-instruction counter and undefined-opcode trap.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             CondEx,
    input  logic             NoWrite,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             undef,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNDEF    = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic             w_irwrite, w_nextpc, w_regw, w_memw, w_branch;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (!CondEx)          w_next = S_FETCH;
                else begin
                    case (Op)
                        2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   w_next = S_MEMADR;
                        2'b10:   w_next = S_BRANCH;
                        default: w_next = S_UNDEF;
                    endcase
                end
            end
            S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_MEMWB:    w_next = S_FETCH;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_UNDEF:    w_next = S_UNDEF;
            default:    w_next = S_UNDEF;
        endcase
    end

    // An instruction retires on any return to FETCH from a working state.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_UNDEF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_count <= r_count + c_one;
        end
    end

    always_comb begin
        w_irwrite = 1'b0;
        w_nextpc  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_branch  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        undef     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_nextpc  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            S_EXECR:    ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    w_regw = !NoWrite;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
            end
            S_UNDEF:    undef = 1'b1;
            default:    undef = 1'b0;
        endcase
    end

    // Architectural side effects are suppressed combinationally during reset.
    assign IRWrite     = w_irwrite & ~reset;
    assign NextPC      = w_nextpc  & ~reset;
    assign RegW        = w_regw    & ~reset;
    assign MemW        = w_memw    & ~reset;
    assign Branch      = w_branch  & ~reset;
    assign state       = r_state;
    assign instr_count = r_count;

endmodule
`default_nettype wire
